// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;
  localparam int DMEM_DEPTH_DEF = 64;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  typedef logic idx_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/response bundle toward the data-memory arbiter
interface dmem_arbiter_if #(parameter int DATA_W = 32);
  logic              req;
  logic              we;
  logic              lock;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic              err;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, err, rdata);
  modport slave (input req, we, lock, addr, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way round-robin picker; on a tie the port not granted last wins
module dmem_rr_pick import dmem_arb_pkg::*; (
  input  logic [1:0] req,
  input  idx_t       last_grant,
  output logic [1:0] gnt
);
  assign gnt = {req[1] & (~req[0] | ~last_grant), req[0] & (~req[1] | last_grant)};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between CPU (r0) and loader (r1) with
// round-robin arbitration, bounded locked bursts, range checking and registered read data.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     r0,
  dmem_arbiter_if.slave     r1,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST - 1);
  state_t state, state_n;
  idx_t last_grant, owner, g_idx;
  logic [CW-1:0] burst_cnt, burst_n;
  logic [1:0] req, we, lock, oor, rr_gnt, gnt, rvalid_q, err_q;
  logic [1:0][DATA_W-1:0] addr, wdata, rdata_q;
  logic hold, force_over;
  assign req   = {r1.req, r0.req};
  assign we    = {r1.we, r0.we};
  assign lock  = {r1.lock, r0.lock};
  assign addr  = {r1.addr, r0.addr};
  assign wdata = {r1.wdata, r0.wdata};
  assign oor   = {r1.addr >= DATA_W'(DMEM_DEPTH), r0.addr >= DATA_W'(DMEM_DEPTH)};
  assign owner = state == OWN1;
  dmem_rr_pick u_pick (.req(req), .last_grant(last_grant), .gnt(rr_gnt));
  // burst_cnt counts locked beats after the first, so force_over fires after MAX_BURST beats
  always_comb begin
    hold       = state != IDLE && req[owner] && lock[owner];
    force_over = hold && burst_cnt == CMAX && req[~owner];
    gnt        = reset ? 2'b00 : (hold && !force_over) ? (owner ? 2'b10 : 2'b01) : rr_gnt;
    g_idx      = gnt[1];
    mem_we     = |gnt && we[g_idx] && !oor[g_idx];
    mem_addr   = |gnt ? addr[g_idx] : '0;
    mem_wd     = |gnt ? wdata[g_idx] : '0;
    state_n    = (!(|gnt) || !lock[g_idx]) ? IDLE : (g_idx ? OWN1 : OWN0);
    burst_n    = (state_n == IDLE || state_n != state) ? '0 : (burst_cnt == CMAX) ? burst_cnt : burst_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_n;
      if (|gnt) last_grant <= g_idx;
      for (int i = 0; i < 2; i++) begin
        rvalid_q[i] <= gnt[i] && (!we[i] || oor[i]);
        err_q[i]    <= gnt[i] && oor[i];
        if (gnt[i] && (!we[i] || oor[i])) rdata_q[i] <= oor[i] ? '0 : mem_rd;
      end
    end
  end
  // responses are masked while reset is high so an in-flight read never surfaces
  assign r0.gnt    = gnt[0];
  assign r1.gnt    = gnt[1];
  assign r0.rvalid = rvalid_q[0] & ~reset;
  assign r1.rvalid = rvalid_q[1] & ~reset;
  assign r0.err    = err_q[0] & ~reset;
  assign r1.err    = err_q[1] & ~reset;
  assign r0.rdata  = reset ? '0 : rdata_q[0];
  assign r1.rdata  = reset ? '0 : rdata_q[1];
endmodule
